// File: rtl/serial_frame_rx.sv
// Serial frame receiver: deserializes LANES bits per enabled cycle into
// WORD_W-bit words, hunts for a sync word, confirms lock over LOCK_CNT
// frames, then delivers aligned data words with valid/frame markers.
// Lock is dropped after MISS_MAX consecutive bad syncs and hunting resumes.
module serial_frame_rx #(
  parameter int unsigned       LANES     = 1,
  parameter int unsigned       WORD_W    = 32,
  parameter logic [WORD_W-1:0] SYNC_WORD = 32'hA5C3_5A3C,
  parameter int unsigned       FRAME_LEN = 8,
  parameter int unsigned       LOCK_CNT  = 2,
  parameter int unsigned       MISS_MAX  = 2,
  parameter bit                MSB_FIRST = 1'b1
) (
  input  logic              t_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [LANES-1:0]  data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_start,
  output logic              locked,
  output logic              sync_err,
  output logic              lock_lost
);

  localparam int unsigned BEATS = WORD_W / LANES;
  localparam int unsigned BW    = $clog2(BEATS + 1);
  localparam int unsigned WW    = $clog2(FRAME_LEN + 1);
  localparam int unsigned GW    = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW    = $clog2(MISS_MAX + 1);

  localparam logic [BW-1:0] BEATS_C    = BW'(BEATS);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [WW-1:0] FRAME_LAST = WW'(FRAME_LEN);
  localparam logic [WW-1:0] WCNT_ONE   = WW'(1);
  localparam logic [GW-1:0] LOCK_C     = GW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_C     = MW'(MISS_MAX);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t            state_q;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     fill_q, fill_d;
  logic [BW-1:0]     beat_q;
  logic [WW-1:0]     wcnt_q;
  logic [GW-1:0]     good_q, good_inc;
  logic [MW-1:0]     miss_q, miss_inc;
  logic              sync_hit;
  logic              word_done;

  logic [WORD_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              frame_start_q;
  logic              locked_q;
  logic              sync_err_q;
  logic              lock_lost_q;

  // Next shift-register value, saturating fill count and per-slice decodes.
  always_comb begin
    if (MSB_FIRST) begin
      sr_d = (sr_q << LANES) | WORD_W'(data_in);
    end else begin
      sr_d = (sr_q >> LANES) | (WORD_W'(data_in) << (WORD_W - LANES));
    end
    fill_d    = (fill_q == BEATS_C) ? fill_q : fill_q + BW'(1);
    sync_hit  = (sr_d == SYNC_WORD);
    word_done = (beat_q == LAST_BEAT);
    good_inc  = good_q + GW'(1);
    miss_inc  = miss_q + MW'(1);
  end

  // Alignment FSM with registered outputs; everything holds when en is low.
  always_ff @(posedge t_clk) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      sr_q          <= '0;
      fill_q        <= '0;
      beat_q        <= '0;
      wcnt_q        <= '0;
      good_q        <= '0;
      miss_q        <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      lock_lost_q   <= 1'b0;
      if (en) begin
        sr_q   <= sr_d;
        fill_q <= fill_d;
        case (state_q)
          HUNT: begin
            // Slice-granular search; only meaningful once sr is fully populated.
            if ((fill_d == BEATS_C) && sync_hit) begin
              beat_q <= '0;
              wcnt_q <= WCNT_ONE;
              good_q <= GW'(1);
              miss_q <= '0;
              if (LOCK_CNT == 1) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                state_q <= CHECK;
              end
            end
          end
          default: begin
            beat_q <= word_done ? '0 : beat_q + BW'(1);
            if (word_done) begin
              if (wcnt_q != '0) begin
                // Data slot: deliver only once locked; CHECK discards it.
                wcnt_q <= (wcnt_q == FRAME_LAST) ? '0 : wcnt_q + WW'(1);
                if (state_q == LOCKED) begin
                  data_out_q    <= sr_d;
                  data_valid_q  <= 1'b1;
                  frame_start_q <= (wcnt_q == WCNT_ONE);
                end
              end else if (sync_hit) begin
                wcnt_q <= WCNT_ONE;
                if (state_q == CHECK) begin
                  good_q <= good_inc;
                  if (good_inc == LOCK_C) begin
                    state_q  <= LOCKED;
                    locked_q <= 1'b1;
                  end
                end else begin
                  miss_q <= '0;
                end
              end else begin
                sync_err_q <= 1'b1;
                if ((state_q == CHECK) || (miss_inc == MISS_C)) begin
                  // Abandon alignment; fill stays full so hunting resumes at once.
                  state_q     <= HUNT;
                  beat_q      <= '0;
                  wcnt_q      <= '0;
                  good_q      <= '0;
                  miss_q      <= '0;
                  locked_q    <= 1'b0;
                  lock_lost_q <= (state_q == LOCKED);
                end else begin
                  // Flywheel: keep the current frame timing through a bad sync.
                  miss_q <= miss_inc;
                  wcnt_q <= WCNT_ONE;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign lock_lost   = lock_lost_q;

endmodule
